// File: rtl/stack_engine.sv
// Parametrised operand stack: PUSH/POP/REPLACE/DUP/SWAP/DROP2/CLEAR with tos/nos views and sticky error flags.
// Optional STACK_ENGINE_PEEK_EN adds a combinational random-access peek port (peek_idx/peek_data/peek_valid).
module stack_engine #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din,
  input  logic             err_clr,
`ifdef STACK_ENGINE_PEEK_EN
  input  logic [PTR_W-1:0] peek_idx,
  output logic [WIDTH-1:0] peek_data,
  output logic             peek_valid,
`endif
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [PTR_W:0]   count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  typedef enum logic [2:0] {
    OP_NOP     = 3'b000,
    OP_PUSH    = 3'b001,
    OP_POP     = 3'b010,
    OP_REPLACE = 3'b011,
    OP_DUP     = 3'b100,
    OP_SWAP    = 3'b101,
    OP_DROP2   = 3'b110,
    OP_CLEAR   = 3'b111
  } op_e;

  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] CNT_TWO  = (PTR_W+1)'(2);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic [PTR_W:0]   cnt_m1, cnt_m2;
  logic [PTR_W-1:0] wr_idx, tos_idx, nos_idx;
  logic             has1, has2, is_full;
  logic             ovf_err, udf_err;

  assign cnt_m1  = count_q - CNT_ONE;
  assign cnt_m2  = count_q - CNT_TWO;
  assign wr_idx  = count_q[PTR_W-1:0];
  assign tos_idx = cnt_m1[PTR_W-1:0];
  assign nos_idx = cnt_m2[PTR_W-1:0];
  assign has1    = (count_q >= CNT_ONE);
  assign has2    = (count_q >= CNT_TWO);
  assign is_full = (count_q == CNT_FULL);

  assign tos       = has1 ? mem_q[tos_idx] : '0;
  assign nos       = has2 ? mem_q[nos_idx] : '0;
  assign count     = count_q;
  assign empty     = !has1;
  assign full      = is_full;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // Illegal ops raise a flag and leave both the array and count untouched.
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    ovf_err = 1'b0;
    udf_err = 1'b0;
    if (op_valid) begin
      case (op_e'(op))
        OP_PUSH: begin
          if (is_full) begin
            ovf_err = 1'b1;
          end else begin
            mem_d[wr_idx] = din;
            count_d       = count_q + CNT_ONE;
          end
        end
        OP_POP: begin
          if (!has1) udf_err = 1'b1;
          else       count_d = cnt_m1;
        end
        OP_REPLACE: begin
          if (!has2) begin
            udf_err = 1'b1;
          end else begin
            mem_d[nos_idx] = din;
            count_d        = cnt_m1;
          end
        end
        OP_DUP: begin
          if (!has1) begin
            udf_err = 1'b1;
          end else if (is_full) begin
            ovf_err = 1'b1;
          end else begin
            mem_d[wr_idx] = mem_q[tos_idx];
            count_d       = count_q + CNT_ONE;
          end
        end
        OP_SWAP: begin
          if (!has2) begin
            udf_err = 1'b1;
          end else begin
            mem_d[tos_idx] = mem_q[nos_idx];
            mem_d[nos_idx] = mem_q[tos_idx];
          end
        end
        OP_DROP2: begin
          if (!has2) udf_err = 1'b1;
          else       count_d = cnt_m2;
        end
        OP_CLEAR: count_d = '0;
        default:  ;
      endcase
    end
    // A fresh error in the same cycle as err_clr keeps its flag set.
    overflow_d  = ovf_err | (overflow_q  & ~err_clr);
    underflow_d = udf_err | (underflow_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; writes are suppressed while reset is held so an aborted op leaves no trace.
  always_ff @(posedge clk) begin
    if (reset) mem_q <= mem_d;
  end

`ifdef STACK_ENGINE_PEEK_EN
  logic [PTR_W:0] peek_pos;

  assign peek_pos   = cnt_m1 - {1'b0, peek_idx};
  assign peek_valid = ({1'b0, peek_idx} < count_q);
  assign peek_data  = peek_valid ? mem_q[peek_pos[PTR_W-1:0]] : '0;
`endif

endmodule

// File: tb/tb_stack_engine.sv
// Directed self-checking bench for stack_engine at WIDTH=8, DEPTH=4.
module tb_stack_engine;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [2:0] NOP = 3'b000, PUSH = 3'b001, POP = 3'b010, REPL = 3'b011,
                         DUP = 3'b100, SWAP = 3'b101, DROP2 = 3'b110, CLR = 3'b111;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             op_valid = 1'b0;
  logic [2:0]       op = NOP;
  logic [WIDTH-1:0] din = '0;
  logic             err_clr = 1'b0;
  logic [WIDTH-1:0] tos, nos;
  logic [PTR_W:0]   count;
  logic             empty, full, overflow, underflow;
`ifdef STACK_ENGINE_PEEK_EN
  logic [PTR_W-1:0] peek_idx = '0;
  logic [WIDTH-1:0] peek_data;
  logic             peek_valid;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  stack_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .op_valid  (op_valid),
    .op        (op),
    .din       (din),
    .err_clr   (err_clr),
`ifdef STACK_ENGINE_PEEK_EN
    .peek_idx  (peek_idx),
    .peek_data (peek_data),
    .peek_valid(peek_valid),
`endif
    .tos       (tos),
    .nos       (nos),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Drive one op at the falling edge, let it commit, then sample 1 time unit after the rising edge.
  task automatic step(input logic [2:0] o, input logic [7:0] d, input logic v, input logic clr);
    @(negedge clk);
    op_valid = v;
    op       = o;
    din      = d;
    err_clr  = clr;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op       = NOP;
    err_clr  = 1'b0;
  endtask

  initial begin
    #12;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full",  32'(full), 0);
    check("rst_tos",   32'(tos), 0);
    check("rst_nos",   32'(nos), 0);
    check("rst_ovf",   32'(overflow), 0);
    check("rst_udf",   32'(underflow), 0);
    @(negedge clk);
    reset = 1'b1;

    // 1: three pushes
    step(PUSH, 8'h05, 1, 0);
    step(PUSH, 8'h07, 1, 0);
    step(PUSH, 8'h09, 1, 0);
    check("t1_tos",   32'(tos), 32'h09);
    check("t1_nos",   32'(nos), 32'h07);
    check("t1_count", 32'(count), 3);
    check("t1_empty", 32'(empty), 0);
    check("t1_full",  32'(full), 0);
    step(CLR, 0, 1, 0);

    // 2: pop on empty, then clear flag
    step(POP, 0, 1, 0);
    check("t2_udf",   32'(underflow), 1);
    check("t2_count", 32'(count), 0);
    check("t2_tos",   32'(tos), 0);
    step(NOP, 0, 0, 1);
    check("t2_udf_clr", 32'(underflow), 0);

    // 3: fill then overflow
    step(PUSH, 8'h01, 1, 0);
    step(PUSH, 8'h02, 1, 0);
    step(PUSH, 8'h03, 1, 0);
    step(PUSH, 8'h04, 1, 0);
    check("t3_full_pre", 32'(full), 1);
    check("t3_ovf_pre",  32'(overflow), 0);
    step(PUSH, 8'hAA, 1, 0);
    check("t3_ovf",   32'(overflow), 1);
    check("t3_full",  32'(full), 1);
    check("t3_tos",   32'(tos), 32'h04);
    check("t3_count", 32'(count), 4);
    step(DUP, 0, 1, 0);
    check("t3_dup_ovf",   32'(overflow), 1);
    check("t3_dup_count", 32'(count), 4);
    check("t3_dup_nos",   32'(nos), 32'h03);
    step(CLR, 0, 1, 1);
    check("t3_clr_ovf", 32'(overflow), 0);

    // 4: replace then swap underflow
    step(PUSH, 8'h05, 1, 0);
    step(PUSH, 8'h07, 1, 0);
    step(REPL, 8'h0C, 1, 0);
    check("t4_count", 32'(count), 1);
    check("t4_tos",   32'(tos), 32'h0C);
    check("t4_nos",   32'(nos), 0);
    step(SWAP, 0, 1, 0);
    check("t4_udf",   32'(underflow), 1);
    check("t4_tos2",  32'(tos), 32'h0C);
    check("t4_count2", 32'(count), 1);
    step(CLR, 0, 1, 1);

    // 5: swap, drop2, failed drop2, clear keeps flags
    step(PUSH, 8'h01, 1, 0);
    step(PUSH, 8'h02, 1, 0);
    step(PUSH, 8'h03, 1, 0);
    step(SWAP, 0, 1, 0);
    check("t5_tos", 32'(tos), 32'h02);
    check("t5_nos", 32'(nos), 32'h03);
    step(DROP2, 0, 1, 0);
    check("t5_d2_count", 32'(count), 1);
    check("t5_d2_tos",   32'(tos), 32'h01);
    step(DROP2, 0, 1, 0);
    check("t5_d2_udf",   32'(underflow), 1);
    check("t5_d2_keep",  32'(count), 1);
    step(DUP, 0, 1, 0);
    check("t5_dup_count", 32'(count), 2);
    check("t5_dup_nos",   32'(nos), 32'h01);
    step(CLR, 0, 1, 0);
    check("t5_clr_count", 32'(count), 0);
    check("t5_clr_empty", 32'(empty), 1);
    check("t5_clr_udf",   32'(underflow), 1);

    // 8: err_clr together with a new underflow
    step(POP, 0, 1, 1);
    check("t8_udf", 32'(underflow), 1);
    step(NOP, 0, 1, 1);
    check("t8_udf_clr", 32'(underflow), 0);

    // op_valid low: no state change
    step(PUSH, 8'h55, 0, 0);
    check("nv_count", 32'(count), 0);

    // 6: reset mid-cycle with a push in flight
    step(PUSH, 8'h22, 1, 0);
    @(negedge clk);
    op_valid = 1'b1;
    op       = PUSH;
    din      = 8'h44;
    #2;
    reset = 1'b0;
    #1;
    check("t6_count_async", 32'(count), 0);
    check("t6_tos_async",   32'(tos), 0);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op       = NOP;
    check("t6_count_held", 32'(count), 0);
    @(negedge clk);
    reset = 1'b1;
    step(PUSH, 8'h11, 1, 0);
    check("t6_tos",   32'(tos), 32'h11);
    check("t6_count", 32'(count), 1);
    check("t6_nos",   32'(nos), 0);

`ifdef STACK_ENGINE_PEEK_EN
    // 7: peek
    step(CLR, 0, 1, 0);
    step(PUSH, 8'h01, 1, 0);
    step(PUSH, 8'h02, 1, 0);
    step(PUSH, 8'h03, 1, 0);
    peek_idx = 2'd2;
    #1;
    check("t7_p2_data",  32'(peek_data), 32'h01);
    check("t7_p2_valid", 32'(peek_valid), 1);
    peek_idx = 2'd0;
    #1;
    check("t7_p0_data",  32'(peek_data), 32'h03);
    peek_idx = 2'd3;
    #1;
    check("t7_p3_valid", 32'(peek_valid), 0);
    check("t7_p3_data",  32'(peek_data), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
